// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE = 4'd0,
        MULT     = 4'd1,
        MULTU    = 4'd2,
        DIV      = 4'd3,
        DIVU     = 4'd4,
        MTHI     = 4'd5,
        MTLO     = 4'd6,
        MFHI     = 4'd7,
        MFLO     = 4'd8
    } mdu_op_e;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for several cycles and write HI/LO on completion.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {hi, lo} for one op.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] rt_mag_safe;
    logic [31:0] rt_u_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        rt_zero;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes; 0x80000000 keeps its unsigned value 2^31.
    assign rt_zero     = (rt == 32'd0);
    assign rs_mag      = rs[31] ? (32'd0 - rs) : rs;
    assign rt_mag      = rt[31] ? (32'd0 - rt) : rt;
    assign rt_mag_safe = rt_zero ? 32'd1 : rt_mag;
    assign rt_u_safe   = rt_zero ? 32'd1 : rt;
    assign q_mag       = rs_mag / rt_mag_safe;
    assign r_mag       = rs_mag % rt_mag_safe;
    assign q_s         = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s         = rs[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u         = rs / rt_u_safe;
    assign r_u         = rs % rt_u_safe;

    always_comb begin
        result      = '0;
        div_by_zero = 1'b0;
        case (mdu_op_e'(op))
            MULT:  result = prod_s;
            MULTU: result = prod_u;
            DIV: begin
                result      = {r_s, q_s};
                div_by_zero = rt_zero;
            end
            DIVU: begin
                result      = {r_u, q_u};
                div_by_zero = rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage MDU: owns HI/LO, models multi-cycle latency, serves MFHI/MFLO.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdu_en,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        mdu_hazard,
    output logic [31:0] mdu_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] issue_cnt;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             pend_dz;
    logic [63:0]      calc_res;
    logic             calc_dz;
    logic             issue;
    mdu_op_e          op;

    mdu_calc u_calc (
        .op          (mdu_op),
        .rs          (rs_data),
        .rt          (rt_data),
        .result      (calc_res),
        .div_by_zero (calc_dz)
    );

    assign op         = mdu_op_e'(mdu_op);
    assign busy       = (cnt != '0);
    assign issue      = mdu_en && !busy && is_multi_cycle(mdu_op);
    assign issue_cnt  = is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign mdu_hazard = busy || (mdu_en && is_multi_cycle(mdu_op));

    // Result is held in pending regs and committed on the last busy cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1) && !pend_dz) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (issue) begin
            cnt     <= issue_cnt;
            pend_hi <= calc_res[63:32];
            pend_lo <= calc_res[31:0];
            pend_dz <= calc_dz;
        end else if (mdu_en) begin
            if (op == MTHI) hi <= rs_data;
            if (op == MTLO) lo <= rs_data;
        end
    end

    always_comb begin
        mdu_out = '0;
        if (mdu_en) begin
            if (op == MFHI)      mdu_out = hi;
            else if (op == MFLO) mdu_out = lo;
        end
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It sits beside the ALU and feeds the E_MDUout input of the E/M pipeline register.
- Owns the architectural HI/LO registers and models multi-cycle MULT/MULTU/DIV/DIVU latency with a busy counter.
- Serves MFHI/MFLO reads combinationally and MTHI/MTLO writes in one cycle.
- Exposes a hazard signal the stall logic uses to freeze the D stage.

Parameters:
- MULT_CYCLES, 5, busy cycles after a MULT/MULTU issue.
- DIV_CYCLES, 10, busy cycles after a DIV/DIVU issue.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- mdu_en  in  1  the E-stage instruction is an MDU op this cycle.
- mdu_op  in  4  operation select; encoding is in the shared package.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- busy  out  1  an operation is in flight.
- mdu_hazard  out  1  combinational: busy, or (mdu_en and mdu_op is MULT/MULTU/DIV/DIVU).
- mdu_out  out  32  combinational: HI when mdu_op=MFHI, LO when mdu_op=MFLO, else 0.

Behaviour:
- Reset:
  - Takes effect at the edge where reset=1, including mid-operation.
  - HI=0, LO=0, counter=0, busy=0, pending results=0.
  - Any in-flight result is discarded.
- Issue:
  - Occurs when mdu_en=1, busy=0, and mdu_op is MULT/MULTU/DIV/DIVU at edge t.
  - At that edge: latch the 64-bit result into pending regs and load counter with N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 in cycles t+1 through t+N.
  - At the edge ending cycle t+N, the counter reaches 0, HI/LO take pending values and busy drops.
  - New HI/LO are visible on mdu_out from cycle t+N+1.
- Counter:
  - Width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
  - Decrements by 1 per cycle while nonzero and never wraps.
- MULT/MULTU: full 64-bit product, signed or unsigned. HI=product[63:32], LO=product[31:0].
- DIV (signed):
  - Quotient truncates toward zero → LO. Remainder carries the sign of the dividend → HI.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient → LO, remainder → HI.
- Divide by zero (rt_data=0): busy still asserts for DIV_CYCLES; HI and LO are unchanged at completion.
- MTHI/MTLO: with mdu_en=1 and busy=0, HI (or LO) := rs_data at that edge. busy is not asserted.
- Ops with mdu_en=1 while busy=1 are ignored: no state change. The hazard unit guarantees this does not occur, and the bench checks that state is still unchanged if it does.
- mdu_out ignores busy; the stall logic prevents an MFHI/MFLO from reaching E while busy.
- mdu_en=0: no state change, and mdu_out=0.
- Reset and issue in the same cycle: reset wins.
- Completion and a new issue cannot overlap, because issue requires busy=0. Back-to-back is allowed: a new issue at the edge where busy is first 0 again.

Decomposition:
- Shared package (mdu_pkg) holds:
  - Op codes: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - Default latencies.
  - A helper that classifies an op code as a multi-cycle op.
- One sub-module, mdu_calc: purely combinational. Takes (op, rs, rt) and produces a 64-bit {hi, lo} plus a div_by_zero flag.
- e_mdu holds the counter, pending regs, HI/LO and the output muxing.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFF rt=2 → busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7) rt=2 → busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/2 → LO=3, HI=1.
- MTHI rs=0x12345678, then MFLO with MTLO 0xCAFEBABE the next cycle → MFHI returns 0x12345678 and MFLO returns 0xCAFEBABE with no busy. DIV by 0 after that → busy 10 cycles, HI/LO unchanged.
- Issue MULT, then raise reset in cycle 3 of busy → busy=0, HI=LO=0 the next cycle; the discarded product never appears.
- While busy, drive MTLO 0xDEADBEEF and a second MULT → both ignored; LO ends at the first MULT result and busy is exactly 5 cycles. mdu_hazard is 1 in the issue cycle and every busy cycle.
- Back-to-back MULT issued on the first non-busy cycle → second busy window begins immediately; HI/LO update twice with the correct values.
